// File: rtl/mc_control_unit_pkg.sv
// =============================================================================
// mc_control_unit_pkg: opcode/ALU constants, class/state enums, control bundle
// Revision 1.0
// =============================================================================
`default_nettype none

package mc_control_unit_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef enum logic [2:0] {
    RFWD_ALU   = 3'd0,
    RFWD_MEM   = 3'd1,
    RFWD_IMM   = 3'd2,
    RFWD_PCIMM = 3'd3,
    RFWD_PC4   = 3'd4
  } rfwd_sel_e;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_R   = 4'd0,
    CLS_I   = 4'd1,
    CLS_L   = 4'd2,
    CLS_S   = 4'd3,
    CLS_B   = 4'd4,
    CLS_LU  = 4'd5,
    CLS_AU  = 4'd6,
    CLS_J   = 4'd7,
    CLS_JL  = 4'd8,
    CLS_ILL = 4'd9
  } op_class_e;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src;
    rfwd_sel_e  rfwd_sel;
    logic       branch;
    logic       jal;
    logic       jalr;
  } ctrl_t;

  function automatic op_class_e classify(input logic [6:0] opcode);
    op_class_e cls;
    case (opcode)
      OP_R:    cls = CLS_R;
      OP_I:    cls = CLS_I;
      OP_L:    cls = CLS_L;
      OP_S:    cls = CLS_S;
      OP_B:    cls = CLS_B;
      OP_LU:   cls = CLS_LU;
      OP_AU:   cls = CLS_AU;
      OP_J:    cls = CLS_J;
      OP_JL:   cls = CLS_JL;
      default: cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_control_unit_if.sv
// =============================================================================
// mc_control_unit_if: instruction/data-ready inputs and datapath control strobes
// Revision 1.0
// =============================================================================
`default_nettype none

interface mc_control_unit_if #(
  parameter int RETIRE_W = 32
);
  logic [31:0]         instrCode;
  logic                dataReady;
  logic                regFileWe;
  logic [3:0]          aluControl;
  logic                aluSrcMuxSel;
  logic [2:0]          RFWDSrcMuxSel;
  logic                branch;
  logic                jal;
  logic                jalr;
  logic                PCEn;
  logic                dataWe;
  logic                halt;
  logic [RETIRE_W-1:0] retireCount;

  modport master (
    input  instrCode, dataReady,
    output regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
           branch, jal, jalr, PCEn, dataWe, halt, retireCount
  );

  modport slave (
    output instrCode, dataReady,
    input  regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
           branch, jal, jalr, PCEn, dataWe, halt, retireCount
  );
endinterface

`default_nettype wire

// File: rtl/mc_ctrl_decoder.sv
// =============================================================================
// mc_ctrl_decoder: maps {opcode class, func3, instr[30]} to the control bundle
// Revision 1.0
// =============================================================================
`default_nettype none

module mc_ctrl_decoder
  import mc_control_unit_pkg::*;
(
  input  op_class_e  op_class,
  input  logic [2:0] func3,
  input  logic       instr30,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl          = '0;
    ctrl.alu_ctrl = ALU_ADD;
    ctrl.rfwd_sel = RFWD_ALU;
    case (op_class)
      CLS_R: ctrl.alu_ctrl = {instr30, func3};
      CLS_I: begin
        // Only the shift-right group uses bit 30 to pick arithmetic vs logical.
        ctrl.alu_ctrl = {(func3 == 3'b101) ? instr30 : 1'b0, func3};
        ctrl.alu_src  = 1'b1;
      end
      CLS_L: begin
        ctrl.alu_src  = 1'b1;
        ctrl.rfwd_sel = RFWD_MEM;
      end
      CLS_S:  ctrl.alu_src = 1'b1;
      CLS_B: begin
        ctrl.alu_ctrl = {1'b0, func3};
        ctrl.branch   = 1'b1;
      end
      CLS_LU: begin
        ctrl.alu_src  = 1'b1;
        ctrl.rfwd_sel = RFWD_IMM;
      end
      CLS_AU: begin
        ctrl.alu_src  = 1'b1;
        ctrl.rfwd_sel = RFWD_PCIMM;
      end
      CLS_J: begin
        ctrl.jal      = 1'b1;
        ctrl.rfwd_sel = RFWD_PC4;
      end
      CLS_JL: begin
        ctrl.alu_src  = 1'b1;
        ctrl.jal      = 1'b1;
        ctrl.jalr     = 1'b1;
        ctrl.rfwd_sel = RFWD_PC4;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_unit.sv
// =============================================================================
// mc_control_unit: multi-cycle RV32I sequencing FSM with halt and retire count
// Revision 1.0
// =============================================================================
`default_nettype none

module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  mc_control_unit_if.master bus
);

  state_e              state;
  state_e              next_state;
  op_class_e           op_class;
  op_class_e           decode_class;
  logic [2:0]          func3;
  logic                instr30;
  ctrl_t               ctrl;
  logic [RETIRE_W-1:0] retire_count;

  logic       hold_ctrl;
  logic       reg_file_we;
  logic [2:0] rfwd_sel;
  logic       pc_en;
  logic       data_we;
  logic       halt;
  logic       is_store;
  logic       is_mem_op;
  logic       unused_instr_bits;

  assign decode_class      = classify(bus.instrCode[6:0]);
  assign is_store          = (op_class == CLS_S);
  assign is_mem_op         = (op_class == CLS_L) || is_store;
  assign unused_instr_bits = ^{bus.instrCode[31], bus.instrCode[29:15], bus.instrCode[11:7]};

  mc_ctrl_decoder u_decoder (
    .op_class (op_class),
    .func3    (func3),
    .instr30  (instr30),
    .ctrl     (ctrl)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= FETCH;
      op_class <= CLS_ILL;
      func3    <= 3'b000;
      instr30  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == DECODE) begin
        op_class <= decode_class;
        func3    <= bus.instrCode[14:12];
        instr30  <= bus.instrCode[30];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      retire_count <= '0;
    end else if (pc_en) begin
      retire_count <= retire_count + RETIRE_W'(1);
    end
  end

  always_comb begin
    next_state  = state;
    hold_ctrl   = 1'b0;
    reg_file_we = 1'b0;
    rfwd_sel    = RFWD_ALU;
    pc_en       = 1'b0;
    data_we     = 1'b0;
    halt        = 1'b0;
    case (state)
      FETCH:   next_state = DECODE;
      DECODE:  next_state = (decode_class == CLS_ILL) ? HALT : EXECUTE;
      EXECUTE: begin
        hold_ctrl  = 1'b1;
        next_state = is_mem_op ? MEM : WB;
      end
      MEM: begin
        hold_ctrl = 1'b1;
        data_we   = is_store;
        // The only Mealy path: a store commits in the same cycle memory accepts it.
        if (bus.dataReady) begin
          pc_en      = is_store;
          next_state = is_store ? FETCH : WB;
        end
      end
      WB: begin
        hold_ctrl   = 1'b1;
        rfwd_sel    = ctrl.rfwd_sel;
        reg_file_we = (op_class != CLS_B) && !is_store;
        pc_en       = 1'b1;
        next_state  = FETCH;
      end
      HALT:    halt = 1'b1;
      default: next_state = FETCH;
    endcase
  end

  assign bus.regFileWe     = reg_file_we;
  assign bus.aluControl    = hold_ctrl ? ctrl.alu_ctrl : 4'b0000;
  assign bus.aluSrcMuxSel  = hold_ctrl & ctrl.alu_src;
  assign bus.RFWDSrcMuxSel = rfwd_sel;
  assign bus.branch        = hold_ctrl & ctrl.branch;
  assign bus.jal           = hold_ctrl & ctrl.jal;
  assign bus.jalr          = hold_ctrl & ctrl.jalr;
  assign bus.PCEn          = pc_en;
  assign bus.dataWe        = data_we;
  assign bus.halt          = halt;
  assign bus.retireCount   = retire_count;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
// =============================================================================
// tb_mc_control_unit: directed per-cycle expectations checked by a queue monitor
// Revision 1.0
// =============================================================================
`default_nettype none

module tb_mc_control_unit;

  localparam int RW = 4;

  typedef struct {
    logic          rf_we;
    logic [3:0]    alu;
    logic          src;
    logic [2:0]    wd;
    logic          br;
    logic          jal;
    logic          jalr;
    logic          pc_en;
    logic          d_we;
    logic          halt;
    logic [RW-1:0] rc;
    logic          chk_ctl;
    logic          chk_src;
    logic          chk_wd;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  exp_t          exp_q[$];
  string         name_q[$];
  logic [RW-1:0] rc_m;

  mc_control_unit_if #(.RETIRE_W(RW)) bus ();

  mc_control_unit #(.RETIRE_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, want end before 200000");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin : monitor
    exp_t  e;
    string nm;
    logic  bad;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      bad = (bus.regFileWe !== e.rf_we) || (bus.PCEn !== e.pc_en) ||
            (bus.dataWe !== e.d_we) || (bus.halt !== e.halt) ||
            (bus.retireCount !== e.rc);
      if (e.chk_ctl && ((bus.aluControl !== e.alu) || (bus.branch !== e.br) ||
                        (bus.jal !== e.jal) || (bus.jalr !== e.jalr)))
        bad = 1'b1;
      if (e.chk_src && (bus.aluSrcMuxSel !== e.src)) bad = 1'b1;
      if (e.chk_wd && (bus.RFWDSrcMuxSel !== e.wd)) bad = 1'b1;
      if (bad) begin
        errors++;
        $display("FAIL %s: got we=%b alu=%b src=%b wd=%0d br=%b jal=%b jalr=%b pc=%b dwe=%b halt=%b rc=%0d; want we=%b alu=%b src=%b wd=%0d br=%b jal=%b jalr=%b pc=%b dwe=%b halt=%b rc=%0d",
                 nm, bus.regFileWe, bus.aluControl, bus.aluSrcMuxSel, bus.RFWDSrcMuxSel,
                 bus.branch, bus.jal, bus.jalr, bus.PCEn, bus.dataWe, bus.halt, bus.retireCount,
                 e.rf_we, e.alu, e.src, e.wd, e.br, e.jal, e.jalr, e.pc_en, e.d_we, e.halt, e.rc);
      end
    end
  end

  function automatic exp_t base();
    exp_t e;
    e.rf_we = 0; e.alu = 4'b0000; e.src = 0; e.wd = 3'd0;
    e.br = 0; e.jal = 0; e.jalr = 0; e.pc_en = 0; e.d_we = 0; e.halt = 0;
    e.rc = rc_m; e.chk_ctl = 1; e.chk_src = 1; e.chk_wd = 1;
    return e;
  endfunction

  function automatic exp_t decode_exp();
    exp_t e;
    e = base();
    e.chk_ctl = 0; e.chk_src = 0; e.chk_wd = 0;
    return e;
  endfunction

  // Push the expectation for the current cycle, then advance one clock.
  task automatic cycle(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = no memory access, 1 = load, 2 = store; src/wd of -1 are unchecked
  task automatic run_instr(input string nm, input logic [31:0] ins, input logic [3:0] alu,
                           input int src, input int wd, input logic br, input logic jal,
                           input logic jalr, input logic rfwe, input int kind,
                           input int waits, input logic noise);
    exp_t e;
    exp_t h;
    bus.instrCode = ins;
    bus.dataReady = noise;
    cycle({nm, " fetch"}, base());
    cycle({nm, " decode"}, decode_exp());
    h = base();
    h.alu = alu; h.br = br; h.jal = jal; h.jalr = jalr;
    h.chk_src = (src >= 0); h.src = src[0]; h.chk_wd = 0;
    cycle({nm, " execute"}, h);
    if (kind != 0) begin
      for (int i = 0; i < waits; i++) begin
        bus.dataReady = 1'b0;
        e = h; e.d_we = (kind == 2);
        cycle({nm, " mem wait"}, e);
      end
      bus.dataReady = 1'b1;
      e = h; e.d_we = (kind == 2); e.pc_en = (kind == 2);
      cycle({nm, " mem ready"}, e);
      if (kind == 2) begin
        rc_m = rc_m + 1'b1;
        return;
      end
    end
    bus.dataReady = noise;
    e = h; e.chk_wd = (wd >= 0); e.wd = wd[2:0]; e.rf_we = rfwe; e.pc_en = 1'b1;
    cycle({nm, " wb"}, e);
    rc_m = rc_m + 1'b1;
  endtask

  initial begin
    exp_t e;
    exp_t h;
    checks = 0;
    errors = 0;
    rc_m   = '0;
    reset  = 1'b0;
    bus.instrCode = 32'h0000_0013;
    bus.dataReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cycle("reset state", base());
    reset = 1'b1;

    run_instr("add",   32'h002081B3, 4'b0000,  0,  0, 0, 0, 0, 1, 0, 0, 0);
    run_instr("lw",    32'h0080A283, 4'b0000,  1,  1, 0, 0, 0, 1, 1, 2, 0);
    run_instr("sw",    32'h0020A223, 4'b0000,  1, -1, 0, 0, 0, 0, 2, 0, 0);
    run_instr("sw w1", 32'h0020A223, 4'b0000,  1, -1, 0, 0, 0, 0, 2, 1, 1);
    run_instr("jalr",  32'h000280E7, 4'b0000,  1,  4, 0, 1, 1, 1, 0, 0, 1);
    run_instr("bne",   32'h00209463, 4'b0001,  0, -1, 1, 0, 0, 0, 0, 0, 0);
    run_instr("sub",   32'h402081B3, 4'b1000,  0,  0, 0, 0, 0, 1, 0, 0, 1);
    run_instr("srai",  32'h4030D093, 4'b1101,  1,  0, 0, 0, 0, 1, 0, 0, 0);
    run_instr("andi",  32'h4000F093, 4'b0111,  1,  0, 0, 0, 0, 1, 0, 0, 0);
    run_instr("lui",   32'h123450B7, 4'b0000, -1,  2, 0, 0, 0, 1, 0, 0, 0);
    run_instr("auipc", 32'h00001097, 4'b0000, -1,  3, 0, 0, 0, 1, 0, 0, 1);
    run_instr("jal",   32'h000000EF, 4'b0000, -1,  4, 0, 1, 0, 1, 0, 0, 0);

    // Illegal opcode: sticky halt, stray dataReady ignored, only reset exits.
    bus.instrCode = 32'h0000007F;
    bus.dataReady = 1'b0;
    cycle("ill fetch", base());
    cycle("ill decode", decode_exp());
    for (int i = 0; i < 20; i++) begin
      bus.dataReady = i[0];
      e = base(); e.halt = 1'b1;
      cycle("halt", e);
    end
    reset = 1'b0;
    e = base(); e.halt = 1'b1;
    cycle("halt reset edge", e);
    reset = 1'b1;
    rc_m  = '0;
    run_instr("add post-halt", 32'h002081B3, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Reset during a load wait state must not commit the load.
    bus.instrCode = 32'h0080A283;
    bus.dataReady = 1'b0;
    cycle("abort fetch", base());
    cycle("abort decode", decode_exp());
    h = base(); h.src = 1'b1; h.chk_wd = 0;
    cycle("abort execute", h);
    cycle("abort mem wait", h);
    reset = 1'b0;
    cycle("abort mem reset", h);
    reset = 1'b1;
    rc_m  = '0;
    run_instr("add post-abort", 32'h002081B3, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Fifteen more retirements bring a 4-bit counter from 1 around to 0.
    for (int i = 0; i < 15; i++)
      run_instr("addi wrap", 32'h00108093, 4'b0000, 1, 0, 0, 0, 0, 1, 0, 0, i[0]);
    bus.instrCode = 32'h002081B3;
    e = base(); e.rc = '0;
    cycle("wrap to zero", e);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle sequencing FSM for the RV32I multi-cycle core. It decodes the instruction word presented by instruction memory and drives every control strobe of the datapath through FETCH/DECODE/EXECUTE/MEM/WB. It holds off the PC and register-file commit until each instruction's final state, and stalls on a data-memory ready handshake. It also halts on illegal opcodes and counts retired instructions.

## Interface
- RETIRE_W, 32, width of retired-instruction counter
- clk  in  1  core clock
- reset  in  1  synchronous, active-low; sampled on rising clk
- instrCode  in  32  instruction word at current PC; stable while PC is unchanged
- dataReady  in  1  data memory completes access this cycle; sampled in MEM only
- regFileWe  out  1  register-file write enable
- aluControl  out  4  ALU op / branch condition select
- aluSrcMuxSel  out  1  0 = rs2, 1 = immediate
- RFWDSrcMuxSel  out  3  0 ALU, 1 mem data, 2 imm, 3 PC+imm, 4 PC+4
- branch, jal, jalr  out  1 each  PC-source controls; JALR asserts jal and jalr together
- PCEn  out  1  PC load enable
- dataWe  out  1  data-memory write strobe
- halt  out  1  sticky illegal-instruction halt
- retireCount  out  RETIRE_W  instructions committed since reset

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT. Reset (reset=0 at edge) → FETCH, retireCount=0, halt=0. All strobes are 0 in FETCH.
- FETCH → DECODE unconditionally.
- DECODE classifies instrCode[6:0]:
  - R 0110011, I 0010011, L 0000011, S 0100011, B 1100011, LU 0110111, AU 0010111, J 1101111, JL 1100111 → EXECUTE.
  - Any other opcode → HALT.
- Opcode class is registered at the DECODE→EXECUTE edge.
- EXECUTE: drive aluControl, aluSrcMuxSel, branch, jal, jalr. Next state: L or S → MEM, otherwise → WB.
- Hold rule: these five signals are held constant from EXECUTE to the instruction's final state, so the datapath's free-running pipeline registers recapture identical values.
- aluControl encoding:
  - R: {instrCode[30], func3}.
  - I: {func3==101 ? instrCode[30] : 0, func3}.
  - B: {0, func3}.
  - L/S/LU/AU/J/JL: 4'b0000 (ADD).
- aluSrcMuxSel = 1 for I/L/S/JL; 0 for R/B.
- MEM:
  - S: dataWe=1 while in MEM. When dataReady=1: PCEn=1, retire, → FETCH.
  - L: dataWe=0. When dataReady=1 → WB.
  - dataReady=0: stay in MEM with all outputs unchanged (wait states unbounded).
- WB: PCEn=1, retire, → FETCH. regFileWe=1 for all classes except B and S. RFWDSrcMuxSel by class:
  - R/I: 0
  - L: 1
  - LU: 2
  - AU: 3
  - J/JL: 4
- B in WB: regFileWe=0, PCEn=1 only.
- HALT: all strobes 0, halt=1. Exit only by reset.
- retireCount increments by 1 on each PCEn cycle; wraps 2^RETIRE_W−1 → 0 silently.

## Timing
- Cycles per instruction: R/I/B/LU/AU/J/JL = 4; S = 4 + wait cycles; L = 5 + wait cycles.
- All outputs are Moore (decoded from registered state + registered class/instr fields). The only exception is the MEM-state PCEn/next-state, which depends on dataReady.
- regFileWe and PCEn are asserted together in a single cycle; both commit at the same edge.
- Reset mid-instruction: the next cycle is FETCH with all strobes 0. A partially executed instruction is never committed, and no strobe glitches high at the reset edge.
- dataReady=1 outside MEM is ignored.
- PCEn is never asserted in more than one cycle per instruction.

## Structure
- Shared package (with the existing opcode/ALU defines): opcode constants, the ALU ADD encoding, an RFWDSrcMuxSel enum (ALU, MEM, IMM, PCIMM, PC4), and the state enum.
- One sub-module, mc_ctrl_decoder: a combinational map from {opcode class, func3, instr[30]} to the aluControl/aluSrcMuxSel/RFWDSrcMuxSel/branch/jal/jalr bundle.
- The FSM, class register and retire counter live in the top level.

## Test plan
- add x3,x1,x2 (0x002081B3): FETCH..WB in 4 cycles; aluControl=0000, regFileWe=1 and PCEn=1 only in cycle 4, RFWDSrcMuxSel=0; retireCount 0→1.
- lw x5,8(x1) with dataReady low for 2 MEM cycles: total 7 cycles, dataWe=0 throughout, WB has RFWDSrcMuxSel=1 and regFileWe=1.
- sw x2,4(x1) with dataReady=1 immediately: dataWe=1 in cycle 4 only, same cycle as PCEn=1, regFileWe=0.
- jalr x1,0(x5): jal=1, jalr=1, aluSrcMuxSel=1 held over EXECUTE and WB; WB has RFWDSrcMuxSel=4. bne (func3 001) gives aluControl=0001, branch=1, regFileWe=0.
- Opcode 0x0000007F: HALT after DECODE; halt=1 and all strobes 0 for 20 cycles; reset=0 for one edge returns to FETCH with halt=0.
- Reset asserted during L MEM wait: next cycle FETCH, PCEn/regFileWe never asserted, retireCount unchanged-then-0. With RETIRE_W=4, 16 retirements wrap the counter to 0.
